// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC fetch into a DEPTH-entry FIFO with redirect flush.
// Optional FETCH_BYPASS_EN presents the fetched pair combinationally when the queue is empty.
module fetch_queue #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            INSTR_WIDTH  = 32,
  parameter int unsigned            DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]    imem_rdata,
  input  logic                      redirect_en,
  input  logic [ADDR_WIDTH-1:0]     redirect_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [INSTR_WIDTH-1:0]    out_instr,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

  logic empty, full, enq, deq, advance;

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
`ifdef FETCH_BYPASS_EN
    // Empty queue forwards the memory read straight out; a taken bypass pair is not stored.
    out_valid = reset && !redirect_en;
    out_pc    = empty ? fetch_pc_q : pc_mem_q[head_q];
    out_instr = empty ? imem_rdata : instr_mem_q[head_q];
    deq       = out_valid && out_ready && !empty;
    advance   = !redirect_en && (!full || deq);
    enq       = advance && !(empty && out_ready);
`else
    out_valid = !redirect_en && !empty;
    out_pc    = pc_mem_q[head_q];
    out_instr = instr_mem_q[head_q];
    deq       = out_valid && out_ready;
    advance   = !redirect_en && (!full || deq);
    enq       = advance;
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_addr & ~ADDR_WIDTH'(3);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (advance) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      if (enq)     tail_d     = tail_q + PTR_W'(1);
      if (deq)     head_d     = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_VECTOR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[tail_q]    <= fetch_pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build): scoreboard of expected PCs checked on handshakes.
module tb_fetch_queue;

  localparam logic [31:0] IMEM_KEY = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(
    .ADDR_WIDTH   (32),
    .INSTR_WIDTH  (32),
    .DEPTH        (4),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ IMEM_KEY;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start, input int unsigned n);
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock: handshake scored at the falling edge, returns 1 time unit after the rising edge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_out", {32'h0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {32'h0, out_pc}, {32'h0, e});
        chk("sb_instr", {32'h0, out_instr}, {32'h0, e ^ IMEM_KEY});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; redirect_en = 1'b0; redirect_addr = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);

    // Streaming with out_ready high: one cycle latency, occupancy stays at 1.
    reset = 1'b1;
    sb_restart(32'h0, 16);
    #1;
    chk("s0_addr", 64'(imem_addr), 64'd0);
    chk("s0_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("s1_addr", 64'(imem_addr), 64'd4);
    chk("s1_valid", 64'(out_valid), 64'd1);
    chk("s1_pc", 64'(out_pc), 64'd0);
    chk("s1_count", 64'(count), 64'd1);
    cycle();
    chk("s2_addr", 64'(imem_addr), 64'd8);
    chk("s2_count", 64'(count), 64'd1);
    cycle();
    chk("s3_count", 64'(count), 64'd1);

    // Stall: queue fills to DEPTH, fetch_pc stops at 16, head stays stable.
    reset = 1'b0;
    #1;
    chk("rst2_count", 64'(count), 64'd0);
    reset = 1'b1; out_ready = 1'b0;
    sb_restart(32'h0, 16);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_count", 64'(count), 64'((i < 4) ? i : 4));
      chk("stall_addr", 64'(imem_addr), 64'((i < 4) ? 4 * i : 16));
      if (i >= 1) chk("stall_pc", 64'(out_pc), 64'd0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("full_enq_deq_count", 64'(count), 64'd4);
    chk("full_enq_deq_addr", 64'(imem_addr), 64'd20);
    repeat (4) cycle();
    chk("drain_sb_left", 64'(exp_q.size()), 64'd11);

    // Redirect on a full queue: no handshake, flush, aligned target.
    out_ready = 1'b0;
    cycle();
    chk("pre_redir_count", 64'(count), 64'd4);
    redirect_en = 1'b1; redirect_addr = 32'h103; out_ready = 1'b1;
    #1;
    chk("redir_valid", 64'(out_valid), 64'd0);
    cycle();
    redirect_en = 1'b0;
    sb_restart(32'h100, 16);
    #1;
    chk("post_redir_count", 64'(count), 64'd0);
    chk("post_redir_addr", 64'(imem_addr), 64'h100);
    cycle();
    chk("post_redir_valid", 64'(out_valid), 64'd1);
    chk("post_redir_pc", 64'(out_pc), 64'h100);
    repeat (3) cycle();

    // PC wrap past the top of the address space.
    redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFE;
    cycle();
    redirect_en = 1'b0;
    sb_restart(32'hFFFF_FFFC, 16);
    #1;
    chk("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    cycle();
    chk("wrap_addr1", 64'(imem_addr), 64'h0);
    repeat (2) cycle();

    // Asynchronous reset mid-cycle with three entries queued and a redirect pending.
    redirect_en = 1'b1; redirect_addr = 32'h200; out_ready = 1'b0;
    cycle();
    redirect_en = 1'b0;
    repeat (3) cycle();
    chk("pre_arst_count", 64'(count), 64'd3);
    #2;
    reset = 1'b0; redirect_en = 1'b1; redirect_addr = 32'h300;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'd0);
    @(posedge clk);
    #1;
    redirect_en = 1'b0; out_ready = 1'b1; reset = 1'b1;
    sb_restart(32'h0, 16);
    #1;
    chk("rel_addr", 64'(imem_addr), 64'd0);
    cycle();
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_pc", 64'(out_pc), 64'd0);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
